// File: rtl/rvc_mem_wrap_lat_if.sv
// D_MEM request/response bundle between the rvc core and its memory wrapper.
// The core side is the master; the wrapper side is the slave.
interface rvc_mem_wrap_lat_if;
    logic        DMemReq;
    logic        DMemReady;
    logic        DMemWrEn;
    logic [31:0] DMemAddr;
    logic [3:0]  DMemByteEn;
    logic [31:0] DMemWrData;
    logic        DMemSignExt;
    logic        DMemRdValid;
    logic [31:0] DMemRdData;
    logic        DMemErr;

    modport master (
        output DMemReq, DMemWrEn, DMemAddr, DMemByteEn,
        output DMemWrData, DMemSignExt,
        input  DMemReady, DMemRdValid, DMemRdData, DMemErr
    );

    modport slave (
        input  DMemReq, DMemWrEn, DMemAddr, DMemByteEn,
        input  DMemWrData, DMemSignExt,
        output DMemReady, DMemRdValid, DMemRdData, DMemErr
    );
endinterface

// File: rtl/rvc_mem_wrap_lat.sv
// I_MEM/D_MEM wrapper for the rvc core: combinational fetch, and a D_MEM
// port with valid/ready requests, configurable read latency and load shaping.
module rvc_mem_wrap_lat #(
    parameter int unsigned I_MEM_ADDR_W = 12,
    parameter int unsigned D_MEM_ADDR_W = 12,
    parameter logic [31:0] D_MEM_BASE   = 32'h0000_1000,
    parameter int unsigned RD_LATENCY   = 1
) (
    input  logic                    Clock,
    input  logic                    Rst,
    input  logic [31:0]             Pc,
    output logic [31:0]             Instruction,
    output logic                    IFetchErr,
    input  logic                    IMemLdEn,
    input  logic [I_MEM_ADDR_W-1:0] IMemLdAddr,
    input  logic [31:0]             IMemLdData,
    rvc_mem_wrap_lat_if.slave       dBus
);

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [32:0] I_TOP  = 33'd1 << (I_MEM_ADDR_W + 2);
    localparam logic [32:0] D_LO   = {1'b0, D_MEM_BASE};
    localparam logic [32:0] D_HI   = D_LO + (33'd1 << (D_MEM_ADDR_W + 2));
    localparam logic [2:0]  LAT    = 3'(RD_LATENCY);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    logic [31:0] iMem [2**I_MEM_ADDR_W];
    logic [31:0] dMem [2**D_MEM_ADDR_W];

    state_t state, stateNxt;
    logic [2:0] count, countNxt;
    logic rdValidQ, rdValidNxt;
    logic errQ, errNxt;
    logic [31:0] rdDataQ, rdDataNxt;

    logic [D_MEM_ADDR_W-1:0] rdIdx;
    logic [3:0] rdBe;
    logic rdSext;
    logic rdLegal;

    logic beOk, inRange, legal, accept;
    logic [D_MEM_ADDR_W-1:0] idx;
    logic [31:0] word, shaped;
    logic pcBad;

    // Image load port: the only way to populate I_MEM
    always_ff @(posedge Clock) begin
        if (IMemLdEn) iMem[IMemLdAddr] <= IMemLdData;
    end

    assign pcBad = (Pc[1:0] != 2'b00) || ({1'b0, Pc} >= I_TOP);
    assign IFetchErr = pcBad;
    assign Instruction = pcBad ? NOP : iMem[Pc[I_MEM_ADDR_W+1:2]];

    always_comb begin
        beOk = 1'b0;
        case (dBus.DMemByteEn)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: beOk = 1'b1;
            default: beOk = 1'b0;
        endcase
    end

    assign inRange = ({1'b0, dBus.DMemAddr} >= D_LO)
                  && ({1'b0, dBus.DMemAddr} < D_HI);
    assign legal   = beOk && inRange;
    assign idx     = dBus.DMemAddr[D_MEM_ADDR_W+1:2];
    assign accept  = dBus.DMemReq && dBus.DMemReady;

    always_ff @(posedge Clock) begin
        if (accept && dBus.DMemWrEn && legal) begin
            for (int i = 0; i < 4; i++) begin
                if (dBus.DMemByteEn[i])
                    dMem[idx][8*i +: 8] <= dBus.DMemWrData[8*i +: 8];
            end
        end
    end

    // Read context is captured at accept; D_MEM cannot change while a read waits
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            rdIdx   <= '0;
            rdBe    <= '0;
            rdSext  <= 1'b0;
            rdLegal <= 1'b0;
        end else if (accept && !dBus.DMemWrEn) begin
            rdIdx   <= idx;
            rdBe    <= dBus.DMemByteEn;
            rdSext  <= dBus.DMemSignExt;
            rdLegal <= legal;
        end
    end

    always_comb begin
        word   = dMem[rdIdx];
        shaped = word;
        unique case (1'b1)
            rdBe == 4'b0001: shaped = {{24{rdSext & word[7]}},  word[7:0]};
            rdBe == 4'b0010: shaped = {{24{rdSext & word[15]}}, word[15:8]};
            rdBe == 4'b0100: shaped = {{24{rdSext & word[23]}}, word[23:16]};
            rdBe == 4'b1000: shaped = {{24{rdSext & word[31]}}, word[31:24]};
            rdBe == 4'b0011: shaped = {{16{rdSext & word[15]}}, word[15:0]};
            rdBe == 4'b1100: shaped = {{16{rdSext & word[31]}}, word[31:16]};
            default:         shaped = word;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            count    <= '0;
            rdValidQ <= 1'b0;
            errQ     <= 1'b0;
            rdDataQ  <= '0;
        end else begin
            state    <= stateNxt;
            count    <= countNxt;
            rdValidQ <= rdValidNxt;
            errQ     <= errNxt;
            rdDataQ  <= rdDataNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        countNxt   = count;
        rdValidNxt = 1'b0;
        errNxt     = 1'b0;
        rdDataNxt  = rdDataQ;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (dBus.DMemWrEn) begin
                        errNxt = !legal;
                    end else begin
                        stateNxt = RD_WAIT;
                        countNxt = 3'd1;
                    end
                end
            end
            RD_WAIT: begin
                if (count >= LAT) begin
                    stateNxt   = IDLE;
                    countNxt   = '0;
                    rdValidNxt = 1'b1;
                    errNxt     = !rdLegal;
                    rdDataNxt  = rdLegal ? shaped : 32'h0;
                end else begin
                    countNxt = count + 3'd1;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign dBus.DMemReady   = (state == IDLE);
    assign dBus.DMemRdValid = rdValidQ;
    assign dBus.DMemRdData  = rdDataQ;
    assign dBus.DMemErr     = errQ;

endmodule

// File: doc/rvc_mem_wrap_lat.md
Name: rvc_mem_wrap_lat

Overview:
Parametrised next-generation I_MEM/D_MEM wrapper for the rvc core.
- I_MEM: combinational instruction fetch, as the single-cycle core requires.
- D_MEM: valid/ready request handshake, configurable read latency, one outstanding read, address-range checking, byte-lane load shaping with sign/zero extension.
- Sits between rvc core and top level; replaces the fixed single-cycle memory wrapper.

Parameters:
I_MEM_ADDR_W, 12, I_MEM word-address width (depth = 2**I_MEM_ADDR_W words)
D_MEM_ADDR_W, 12, D_MEM word-address width (depth = 2**D_MEM_ADDR_W words)
D_MEM_BASE, 32'h0000_1000, byte base address of D_MEM region; must be aligned to region size
RD_LATENCY, 1, D_MEM read latency in cycles, legal 1..4

Ports:
Clock  in  1  clock, all state on rising edge
Rst  in  1  asynchronous active-low reset
Pc  in  32  instruction byte address
Instruction  out  32  fetched instruction
IFetchErr  out  1  Pc misaligned or outside I_MEM
DMemReq  in  1  D_MEM request valid
DMemReady  out  1  wrapper can accept a request this cycle
DMemWrEn  in  1  1=write, 0=read
DMemAddr  in  32  byte address
DMemByteEn  in  4  byte lanes
DMemWrData  in  32  write data, already lane-aligned
DMemSignExt  in  1  loads: 1=sign-extend, 0=zero-extend
DMemRdValid  out  1  read data valid, one-cycle pulse
DMemRdData  out  32  shaped read data
DMemErr  out  1  error pulse for the returned or dropped request

Behaviour:
- Reset (Rst=0, async): state=IDLE, count=0, DMemRdValid=0, DMemRdData=0, DMemErr=0. DMemReady=1 once Rst deasserts. Array contents are not reset.
- Reset mid-read aborts the read: no DMemRdValid is produced.
- I_MEM fetch:
  - Instruction = IMem[Pc[I_MEM_ADDR_W+1:2]], combinational.
  - If Pc[1:0]!=0 or Pc >= 4*2**I_MEM_ADDR_W: Instruction=32'h0000_0013 (NOP) and IFetchErr=1 (combinational).
- Accept: a request is accepted when DMemReq && DMemReady at a rising edge.
- Legal request: DMemByteEn in {0001,0010,0100,1000,0011,1100,1111}, and DMemAddr within [D_MEM_BASE, D_MEM_BASE+4*2**D_MEM_ADDR_W). Word index = DMemAddr[D_MEM_ADDR_W+1:2]. DMemAddr[1:0] is ignored; lanes come from ByteEn.
- Write:
  - Legal: only enabled lanes are written at the accept edge; state stays IDLE.
  - Illegal: write dropped, DMemErr=1 for one cycle after the accept.
  - No DMemRdValid for any write.
- Read:
  - At accept, latch ByteEn, SignExt and legality; state IDLE->RD_WAIT; count=1.
  - Each cycle in RD_WAIT, count increments.
  - When the count reaches RD_LATENCY, the next edge registers DMemRdValid=1 and DMemRdData, and state goes to IDLE.
  - Net effect: request accepted at edge N, data visible after edge N+RD_LATENCY.
- DMemReady = (state==IDLE). One outstanding read; reads sustain one per RD_LATENCY+1 cycles; writes sustain one per cycle.
- Read shaping:
  - Selected lanes are shifted right to bit 0.
  - Byte: bits[7:0], extended from bit 7. Half: bits[15:0], extended from bit 15. Word: unchanged.
  - Extension per the latched SignExt.
  - Illegal read: DMemRdData=0 with DMemRdValid=1 and DMemErr=1 in the same cycle.
- DMemRdValid and DMemErr are single-cycle pulses; DMemRdData holds its value until the next read returns.
- Simultaneous events:
  - DMemReq while DMemReady=0 is ignored; the requester must hold it.
  - A write to the same word as the in-flight read cannot occur, because Ready=0 during RD_WAIT.
- Arithmetic: range check uses full 32-bit unsigned compare; no wrap-around at 2**32.

Test Plan:
- Reset: hold Rst=0 mid-read (RD_LATENCY=3, read accepted one cycle earlier), release -> DMemRdValid never pulses, DMemReady=1, DMemRdData=0.
- Word write/read (RD_LATENCY=2): write 32'hDEAD_BEEF to 0x1004 with ByteEn=1111, then read 0x1004 at edge N -> DMemReady=0 for the cycles between edge N and edge N+2, and DMemRdValid=1 with DMemRdData=32'hDEAD_BEEF after edge N+2.
- Byte shaping: word 0x1008 = 32'h80FF_7F01. Read ByteEn=1000, SignExt=1 -> 32'hFFFF_FF80. Same with SignExt=0 -> 32'h0000_0080. ByteEn=0011, SignExt=1 -> 32'h0000_7F01.
- Partial write: word=0, write ByteEn=0100 data 32'h00AB_0000 -> readback 32'h00AB_0000 with ByteEn=1111; other lanes stay 0.
- Errors:
  - Read 0x0000_0FFC -> DMemRdValid=1, DMemRdData=0, DMemErr=1.
  - Write ByteEn=0101 -> memory unchanged, DMemErr pulse one cycle after the accept.
  - Pc=0x0000_4000 (I_MEM_ADDR_W=12) -> Instruction=32'h0000_0013, IFetchErr=1.
- Back-to-back (RD_LATENCY=1): DMemReq held high for three reads -> one accept every 2 cycles; the 3rd accept falls 4 cycles after the 1st.
